instr_fetch_ctrl: RTL and testbench

- Fetch-side counterpart of the instruction memory. Owns the 8-bit program counter and drives it onto the memory address.
- Samples the 9-bit instruction that the memory returns combinationally and registers it into the IF/ID stage register, together with its PC and a valid flag.
- Handles run/halt control, stalls from downstream, and branch redirects with squash.

---
 rtl/instr_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, registers the IF/ID stage, handles run/halt/stall/branch.
// Optional macro INSTR_FETCH_CNT_EN adds a saturating 16-bit captured-instruction counter (instr_cnt_o).
module instr_fetch_ctrl #(
    parameter int                   PC_W       = 8,
    parameter int                   INSTR_W    = 9,
    parameter logic [PC_W-1:0]      RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    branch_val,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic               instr_valid_o,
`ifdef INSTR_FETCH_CNT_EN
    output logic [15:0]        instr_cnt_o,
`endif
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instrPc;
    logic               r_valid;
    logic               r_done;
    logic [PC_W-1:0]    w_brTarget;

    // Offset is already PC_W wide, so sign extension is the identity and the sum wraps naturally.
    assign w_brTarget = branch_rel ? (r_instrPc + branch_val) : branch_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_instrPc <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pc    <= RESET_PC;
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (start) begin
                        r_pc    <= RESET_PC;
                        r_valid <= 1'b0;
                    end else if (branch_en) begin
                        r_pc    <= w_brTarget;
                        r_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr   <= instr_i;
                        r_instrPc <= r_pc;
                        r_valid   <= 1'b1;
                        if (instr_i == HALT_INSTR) begin
                            r_state <= HALT;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                HALT: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_pc    <= RESET_PC;
                        r_done  <= 1'b0;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_CNT_EN
    logic        w_capture;
    logic [15:0] r_cnt;

    assign w_capture = (r_state == RUN) && !start && !branch_en && !stall;

    // Counts only real captures; start clears it in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (w_capture && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign instr_cnt_o = r_cnt;
`endif

    assign pc            = r_pc;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instrPc;
    assign instr_valid_o = r_valid;
    assign done_o        = r_done;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Table-driven scoreboard bench for instr_fetch_ctrl; memory model returns 9'h010+addr, with HALT at address 7.
module tb_instr_fetch_ctrl;

    typedef struct {
        logic        st;
        logic        sl;
        logic        be;
        logic        br;
        logic [7:0]  bv;
        logic [7:0]  pc;
        logic [8:0]  instr;
        logic [7:0]  ipc;
        logic        v;
        logic        d;
        logic [15:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       branch_en = 1'b0;
    logic       branch_rel = 1'b0;
    logic [7:0] branch_val = 8'h00;
    logic [7:0] pc;
    logic [8:0] instr_i;
    logic [8:0] instr_o;
    logic [7:0] instr_pc_o;
    logic       instr_valid_o;
    logic       done_o;
    logic [15:0] cnt;
    logic [8:0] mem [0:255];

    int assertCnt = 0;
    int failCnt   = 0;
    vec_t vecs[$];
    vec_t expQ[$];

    always #5 clk = ~clk;

    assign instr_i = mem[pc];

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_rel   (branch_rel),
        .branch_val   (branch_val),
        .pc           (pc),
        .instr_i      (instr_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_valid_o(instr_valid_o),
`ifdef INSTR_FETCH_CNT_EN
        .instr_cnt_o  (cnt),
`endif
        .done_o       (done_o)
    );

`ifndef INSTR_FETCH_CNT_EN
    assign cnt = 16'h0000;
`endif

    function automatic vec_t mk(input logic st, input logic sl, input logic be, input logic br,
                                input logic [7:0] bv, input logic [7:0] epc, input logic [8:0] ein,
                                input logic [7:0] eipc, input logic ev, input logic ed,
                                input logic [15:0] ecnt);
        vec_t t;
        t.st = st; t.sl = sl; t.be = be; t.br = br; t.bv = bv;
        t.pc = epc; t.instr = ein; t.ipc = eipc; t.v = ev; t.d = ed; t.cnt = ecnt;
        return t;
    endfunction

    task automatic cmp(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
        assertCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start      = v.st;
        stall      = v.sl;
        branch_en  = v.be;
        branch_rel = v.br;
        branch_val = v.bv;
        expQ.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int step);
        vec_t e;
        if (expQ.size() == 0) begin
            cmp("scoreboard_empty", step, 16'd1, 16'd0);
            return;
        end
        e = expQ.pop_front();
        cmp("pc", step, {8'h00, pc}, {8'h00, e.pc});
        cmp("instr_o", step, {7'h00, instr_o}, {7'h00, e.instr});
        cmp("instr_pc_o", step, {8'h00, instr_pc_o}, {8'h00, e.ipc});
        cmp("instr_valid_o", step, {15'h0, instr_valid_o}, {15'h0, e.v});
        cmp("done_o", step, {15'h0, done_o}, {15'h0, e.d});
`ifdef INSTR_FETCH_CNT_EN
        cmp("instr_cnt_o", step, cnt, e.cnt);
`endif
    endtask

    task automatic checkReset(input int step);
        cmp("rst_pc", step, {8'h00, pc}, 16'h0000);
        cmp("rst_instr_o", step, {7'h00, instr_o}, 16'h0000);
        cmp("rst_instr_pc_o", step, {8'h00, instr_pc_o}, 16'h0000);
        cmp("rst_valid", step, {15'h0, instr_valid_o}, 16'h0000);
        cmp("rst_done", step, {15'h0, done_o}, 16'h0000);
`ifdef INSTR_FETCH_CNT_EN
        cmp("rst_cnt", step, cnt, 16'h0000);
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'(16 + i);
        mem[7] = 9'h1FF;

        //              st sl be br bv     pc     instr   ipc    v  d  cnt
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 9'h000, 8'h00, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 9'h000, 8'h00, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 9'h010, 8'h00, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 9'h011, 8'h01, 1, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h03, 9'h012, 8'h02, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 9'h013, 8'h03, 1, 0, 16'd4));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd5));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd5));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd5));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h06, 9'h015, 8'h05, 1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 1, 0, 8'h10, 8'h10, 9'h015, 8'h05, 0, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h11, 9'h020, 8'h10, 1, 0, 16'd7));
        vecs.push_back(mk(0, 0, 1, 1, 8'hFC, 8'h0C, 9'h020, 8'h10, 0, 0, 16'd7));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h0D, 9'h01C, 8'h0C, 1, 0, 16'd8));
        vecs.push_back(mk(0, 1, 1, 0, 8'h80, 8'h80, 9'h01C, 8'h0C, 0, 0, 16'd8));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h81, 9'h090, 8'h80, 1, 0, 16'd9));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFE, 8'hFE, 9'h090, 8'h80, 0, 0, 16'd9));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFF, 9'h10E, 8'hFE, 1, 0, 16'd10));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 9'h10F, 8'hFF, 1, 0, 16'd11));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 9'h010, 8'h00, 1, 0, 16'd12));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 9'h011, 8'h01, 1, 0, 16'd13));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h03, 9'h012, 8'h02, 1, 0, 16'd14));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 9'h013, 8'h03, 1, 0, 16'd15));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd16));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h06, 9'h015, 8'h05, 1, 0, 16'd17));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h07, 9'h016, 8'h06, 1, 0, 16'd18));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h07, 9'h1FF, 8'h07, 1, 1, 16'd19));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h07, 9'h1FF, 8'h07, 0, 1, 16'd19));
        vecs.push_back(mk(0, 1, 1, 0, 8'h40, 8'h07, 9'h1FF, 8'h07, 0, 1, 16'd19));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 9'h1FF, 8'h07, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 9'h010, 8'h00, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h02, 9'h011, 8'h01, 1, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h03, 9'h012, 8'h02, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 9'h013, 8'h03, 1, 0, 16'd4));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h05, 9'h014, 8'h04, 1, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h06, 9'h015, 8'h05, 1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h07, 9'h016, 8'h06, 1, 0, 16'd7));
        // Branch while the halt word is on instr_i: it must be discarded.
        vecs.push_back(mk(0, 0, 1, 0, 8'h30, 8'h30, 9'h016, 8'h06, 0, 0, 16'd7));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h31, 9'h040, 8'h30, 1, 0, 16'd8));
        vecs.push_back(mk(1, 0, 1, 0, 8'h55, 8'h00, 9'h040, 8'h30, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 9'h010, 8'h00, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 1, 0, 8'h32, 8'h32, 9'h010, 8'h00, 0, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h33, 9'h042, 8'h32, 1, 0, 16'd2));

        @(posedge clk);
        @(posedge clk);
        #1;
        checkReset(-1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Asynchronous reset mid-run at pc=8'h33, checked before any clock edge.
        start = 1'b0; stall = 1'b0; branch_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset(100);
        @(posedge clk);
        #1;
        checkReset(101);
        rst_n = 1'b1;

        // Counter sequence: 5 captures, 1 squash, 2 stalls.
        applyStimulus(mk(1, 0, 0, 0, 8'h00, 8'h00, 9'h000, 8'h00, 0, 0, 16'd0)); checkOutput(200);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h01, 9'h010, 8'h00, 1, 0, 16'd1)); checkOutput(201);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h02, 9'h011, 8'h01, 1, 0, 16'd2)); checkOutput(202);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h03, 9'h012, 8'h02, 1, 0, 16'd3)); checkOutput(203);
        applyStimulus(mk(0, 0, 1, 0, 8'h20, 8'h20, 9'h012, 8'h02, 0, 0, 16'd3)); checkOutput(204);
        applyStimulus(mk(0, 1, 0, 0, 8'h00, 8'h20, 9'h012, 8'h02, 0, 0, 16'd3)); checkOutput(205);
        applyStimulus(mk(0, 1, 0, 0, 8'h00, 8'h20, 9'h012, 8'h02, 0, 0, 16'd3)); checkOutput(206);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h21, 9'h030, 8'h20, 1, 0, 16'd4)); checkOutput(207);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h22, 9'h031, 8'h21, 1, 0, 16'd5)); checkOutput(208);

        start = 1'b0; stall = 1'b0; branch_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset(300);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
